fdd_track_loader: RTL and testbench
===================================

FDD_TRACK_LOADER -- requirements
Module: fdd_track_loader

Interface
REQ-001 Parameter SECTORS_PER_TRACK, default 13: 512-byte SD blocks per nibble track (6656 bytes).
REQ-002 Port clk_sys  in  1  system clock; every flop is clocked on its rising edge.
REQ-003 Port reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port track  in  6  track currently selected by the drive model.
REQ-005 Port img_mounted  in  1  one-cycle strobe: a new image is mounted.
REQ-006 Port img_size  in  64  mounted image size in bytes; 0 means no image.
REQ-007 Port sd_lba  out  32  block address presented to the SD host.
REQ-008 Port sd_rd / sd_wr  out  1 each  block read / block write requests.
REQ-009 Port sd_ack  in  1  SD host busy; it rises when the host accepts a request and falls when the block completes.
REQ-010 Port sd_buff_addr  in  9  byte index within the current block.
REQ-011 Port sd_buff_wr  in  1  write strobe for a byte returned by the host.
REQ-012 Port buf_addr  out  13  track buffer address, equal to {sec[3:0], sd_buff_addr}.
REQ-013 Port buf_we  out  1  track buffer write enable, equal to sd_buff_wr & sd_ack & reading.
REQ-014 Port fd_write  in  1  drive model wrote one byte into the track buffer.
REQ-015 Port fd_track_addr  in  13  address of that write; bits [12:9] give the sector.
REQ-016 Port cpu_wait  out  1  stalls the CPU while a track transfer is in progress.
REQ-017 Port track_valid  out  1  the buffer holds the currently selected track.

Function
REQ-018 FSM states: IDLE, RD_REQ, RD_XFER, WR_REQ, WR_XFER.
REQ-019 IDLE: a load is triggered when (track != cur_track or a mount is pending) and img_size != 0.
  - Writeback disabled: go to RD_REQ.
  - Writeback enabled: go to WR_REQ if the dirty mask is nonzero, otherwise RD_REQ.
REQ-020 On a load trigger: cur_track <= track, sec <= 0, track_valid <= 0, pending mount cleared.
REQ-021 A load with img_size == 0 is not started: the pending mount is cleared, track_valid is forced to 0, the FSM stays in IDLE.
REQ-022 RD_REQ: sd_lba = 13*cur_track + sec; the product uses a 10-bit intermediate, zero-extended to 32 bits; sd_rd = 1 until the sd_ack rising edge, then go to RD_XFER.
REQ-023 RD_XFER: on the sd_ack falling edge, sec increments.
  - If the new sec equals SECTORS_PER_TRACK: go to IDLE and set track_valid.
  - Otherwise: return to RD_REQ.
REQ-024 sd_rd and sd_wr are never asserted together; each deasserts within 1 cycle of the sd_ack rise.
REQ-025 cpu_wait is 1 in every non-IDLE state and is registered: it rises the cycle after the trigger and falls the cycle after the FSM returns to IDLE.
REQ-026 track changes during a transfer are ignored until IDLE, where they retrigger a load; the lost load costs no extra cycle.
REQ-027 An img_mounted strobe during a transfer sets the pending-mount flag; the current transfer completes first.
REQ-028 fd_write coinciding with a read of the same sector: the buffer write wins and the dirty bit is set.

Reset
REQ-029 Asynchronous assertion of reset_n forces, in the same instant:
  - FSM to IDLE; sd_rd = sd_wr = cpu_wait = track_valid = 0;
  - sd_lba = 0; sec = 0; dirty mask = 0; pending mount = 0;
  - cur_track = 6'h3F, so the first valid mount triggers a load.
REQ-030 Reset asserted mid-transfer abandons the block; no retry follows reset release.
REQ-031 Reset deassertion takes effect at the next clk_sys edge; outputs are never driven X.

Configuration
REQ-032 Macro FDD_WRITEBACK_EN:
  - Defined: fd_write sets dirty[fd_track_addr[12:9]] (13-bit mask).
  - WR_REQ scans from the lowest dirty sector, with sec = that index and sd_lba = 13*cur_track + sec.
  - sd_wr is asserted until the sd_ack rise; the sd_ack fall clears that dirty bit.
  - When the mask is empty, go to RD_REQ for the new track with sec = 0.
REQ-033 Macro FDD_WRITEBACK_EN undefined: fd_write is ignored; the dirty mask and the WR states are absent; sd_wr is tied to 0.

Verification
REQ-034 Mount with img_size=143360, track=0, host acks each block after 520 cycles:
  - exactly 13 reads at lba 0..12;
  - 6656 buf_we pulses;
  - track_valid=1 and cpu_wait=0 afterwards.
REQ-035 Change track 0->5 in IDLE:
  - first sd_lba=65 and the last is 77;
  - cpu_wait is high throughout, and track_valid is 0 until sector 12 completes.
REQ-036 Change track to 7 while the track-3 read is at sector 4: the track-3 load finishes (lba 39..51), then the lba 91..103 load starts without any gap state.
REQ-037 Mount with img_size=0: no sd_rd is issued, track_valid=0, cpu_wait stays 0.
REQ-038 reset_n low for 3 cycles while sd_ack=1 at sector 6: all outputs drop asynchronously; after release no request is issued until the next mount or track change.
REQ-039 With FDD_WRITEBACK_EN: fd_write at 0x0A00 and 0x1800 on track 2, then move to track 3:
  - writes to lba 31 then 38;
  - then reads from lba 39;
  - without the macro, no sd_wr is ever seen.

Source files
------------

// File: rtl/fdd_track_loader.sv
// Loads one nibble track at a time from an SD image into the floppy track buffer.
// Define FDD_WRITEBACK_EN to write dirty sectors back to the image before a track change.
module fdd_track_loader #(
    parameter int SECTORS_PER_TRACK = 13
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [5:0]  track,
    input  logic        img_mounted,
    input  logic [63:0] img_size,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic        sd_buff_wr,
    output logic [12:0] buf_addr,
    output logic        buf_we,
    input  logic        fd_write,
    input  logic [12:0] fd_track_addr,
    output logic        cpu_wait,
    output logic        track_valid
);

    localparam int unsigned SEC_W  = 4;
    localparam int unsigned TRK_W  = 6;
    localparam int unsigned PROD_W = 10;
    localparam int unsigned LBA_W  = 32;
    localparam int unsigned NSEC   = SECTORS_PER_TRACK;
    localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(NSEC - 1);

`ifdef FDD_WRITEBACK_EN
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_XFER, WR_REQ, WR_XFER} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_XFER} state_t;
`endif

    state_t             state_q, state_d;
    logic [TRK_W-1:0]   cur_track_q, cur_track_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic               mount_pend_q, mount_pend_d;
    logic               img_present_q, img_present_d;
    logic               ack_q;
    logic               track_valid_d, cpu_wait_d, sd_rd_d, sd_wr_d;
    logic [LBA_W-1:0]   sd_lba_d;
    logic               size_ok, mount_req, ack_rise, ack_fall, want_load, start;
    logic               unused_fd;

    // 13*track + sector, computed in 10 bits (fits track 63, sector 12)
    function automatic logic [LBA_W-1:0] lba_of(input logic [TRK_W-1:0] t, input logic [SEC_W-1:0] s);
        logic [PROD_W-1:0] p;
        p = PROD_W'(t) * PROD_W'(NSEC) + PROD_W'(s);
        return LBA_W'(p);
    endfunction

    assign size_ok       = (img_size != '0);
    assign mount_req     = mount_pend_q | img_mounted;
    assign img_present_d = img_mounted ? size_ok : img_present_q;
    assign ack_rise      = sd_ack & ~ack_q;
    assign ack_fall      = ~sd_ack & ack_q;
    // Loads only follow a mount of a non-empty image, so reset alone never starts one
    assign want_load     = ((track != cur_track_q) || mount_req) && img_present_d && size_ok;

    assign buf_addr = {sec_q, sd_buff_addr};
    assign buf_we   = sd_buff_wr & sd_ack & ((state_q == RD_REQ) || (state_q == RD_XFER));

`ifdef FDD_WRITEBACK_EN
    logic [NSEC-1:0]    dirty_q, dirty_d;
    logic [TRK_W-1:0]   load_track_q, load_track_d;
    logic [SEC_W-1:0]   fd_sec, first_dirty;

    assign fd_sec    = fd_track_addr[12:9];
    assign unused_fd = &{1'b0, fd_track_addr[8:0]};

    // Dirty mask: a completed writeback clears its bit, a concurrent buffer write re-sets it
    always_comb begin
        dirty_d = dirty_q;
        if ((state_q == WR_XFER) && ack_fall) dirty_d[sec_q] = 1'b0;
        if (fd_write && (32'(fd_sec) < NSEC)) dirty_d[fd_sec] = 1'b1;
        first_dirty = '0;
        for (int i = int'(NSEC) - 1; i >= 0; i--) begin
            if (dirty_d[i]) first_dirty = SEC_W'(i);
        end
    end
`else
    assign unused_fd = &{1'b0, fd_write, fd_track_addr};
    assign sd_wr     = 1'b0;
    assign sd_wr_d   = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        cur_track_d   = cur_track_q;
        sec_d         = sec_q;
        mount_pend_d  = mount_req;
        track_valid_d = track_valid;
        start         = 1'b0;
`ifdef FDD_WRITEBACK_EN
        load_track_d  = load_track_q;
`endif

        case (state_q)
            IDLE: begin
                if (want_load) begin
                    start = 1'b1;
                end else if (mount_req && !size_ok) begin
                    mount_pend_d  = 1'b0;
                    track_valid_d = 1'b0;
                end
            end
            RD_REQ: if (ack_rise) state_d = RD_XFER;
            RD_XFER: begin
                if (ack_fall) begin
                    if (sec_q == LAST_SEC) begin
                        // A track change seen during the load chains straight into the next one
                        if (want_load) begin
                            start = 1'b1;
                        end else begin
                            state_d       = IDLE;
                            track_valid_d = 1'b1;
                        end
                    end else begin
                        sec_d   = sec_q + 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
`ifdef FDD_WRITEBACK_EN
            WR_REQ: if (ack_rise) state_d = WR_XFER;
            WR_XFER: begin
                if (ack_fall) begin
                    if (dirty_d != '0) begin
                        state_d = WR_REQ;
                        sec_d   = first_dirty;
                    end else begin
                        state_d     = RD_REQ;
                        cur_track_d = load_track_q;
                        sec_d       = '0;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (start) begin
            sec_d         = '0;
            track_valid_d = 1'b0;
            mount_pend_d  = 1'b0;
`ifdef FDD_WRITEBACK_EN
            // Old track stays current until its dirty sectors are flushed
            if (dirty_d != '0) begin
                state_d      = WR_REQ;
                load_track_d = track;
                sec_d        = first_dirty;
            end else begin
                state_d     = RD_REQ;
                cur_track_d = track;
            end
`else
            state_d     = RD_REQ;
            cur_track_d = track;
`endif
        end

        sd_rd_d    = (state_d == RD_REQ);
        cpu_wait_d = (state_d != IDLE);
`ifdef FDD_WRITEBACK_EN
        sd_wr_d    = (state_d == WR_REQ);
`endif
        sd_lba_d   = sd_lba;
        if (sd_rd_d || sd_wr_d) sd_lba_d = lba_of(cur_track_d, sec_d);
    end

    // State and output registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cur_track_q   <= 6'h3F;
            sec_q         <= '0;
            mount_pend_q  <= 1'b0;
            img_present_q <= 1'b0;
            ack_q         <= 1'b0;
            track_valid   <= 1'b0;
            cpu_wait      <= 1'b0;
            sd_rd         <= 1'b0;
            sd_lba        <= '0;
        end else begin
            state_q       <= state_d;
            cur_track_q   <= cur_track_d;
            sec_q         <= sec_d;
            mount_pend_q  <= mount_pend_d;
            img_present_q <= img_present_d;
            ack_q         <= sd_ack;
            track_valid   <= track_valid_d;
            cpu_wait      <= cpu_wait_d;
            sd_rd         <= sd_rd_d;
            sd_lba        <= sd_lba_d;
        end
    end

`ifdef FDD_WRITEBACK_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dirty_q      <= '0;
            load_track_q <= '0;
            sd_wr        <= 1'b0;
        end else begin
            dirty_q      <= dirty_d;
            load_track_q <= load_track_d;
            sd_wr        <= sd_wr_d;
        end
    end
`endif

endmodule

// File: tb/tb_fdd_track_loader.sv
// Bench for fdd_track_loader: SD host model with a request scoreboard, a table of
// load scenarios, and hand sequences for retargeting, reset and writeback.
`timescale 1ns/1ps
module tb_fdd_track_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [5:0]  track;
    logic        img_mounted;
    logic [63:0] img_size;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [8:0]  sd_buff_addr;
    logic        sd_buff_wr;
    logic [12:0] buf_addr;
    logic        buf_we;
    logic        fd_write;
    logic [12:0] fd_track_addr;
    logic        cpu_wait, track_valid;

    always #5 clk_sys = ~clk_sys;

    fdd_track_loader dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .track(track), .img_mounted(img_mounted),
        .img_size(img_size), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_wr(sd_buff_wr), .buf_addr(buf_addr),
        .buf_we(buf_we), .fd_write(fd_write), .fd_track_addr(fd_track_addr),
        .cpu_wait(cpu_wait), .track_valid(track_valid)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] lba;
    } req_t;

    typedef struct {
        logic        mount;
        logic [63:0] size;
        logic [5:0]  trk;
        logic        fast;
        logic        exp_load;
        logic        exp_valid;
        int          exp_bw;
    } vec_t;

    req_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         bw_count = 0;
    int         addr_bad = 0;
    int         rdwr_both = 0;
    int         wr_seen = 0;
    logic       host_fast = 1'b1;
    logic [3:0] host_sec = 4'd0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
        #2;
    endtask

    task automatic push_reads(input logic [5:0] trk);
        req_t r;
        for (int s = 0; s < 13; s++) begin
            r.wr  = 1'b0;
            r.lba = 32'(13 * int'(trk) + s);
            exp_q.push_back(r);
        end
    endtask

    task automatic push_write(input int lba);
        req_t r;
        r.wr  = 1'b1;
        r.lba = 32'(lba);
        exp_q.push_back(r);
    endtask

    // Waits for cpu_wait to fall; counts cycles where track_valid is high while busy
    task automatic wait_done(output int tv_hi);
        int n;
        n = 0;
        tv_hi = 0;
        while (cpu_wait === 1'b1 && n < 20000) begin
            if (track_valid) tv_hi++;
            tick();
            n++;
        end
        check("load_timeout", longint'(n >= 20000), 0);
    endtask

    task automatic run_entry(input vec_t v);
        int bw0, seen, tv_hi;
        bw0  = bw_count;
        seen = 0;
        host_fast   = v.fast;
        track       = v.trk;
        img_size    = v.size;
        img_mounted = v.mount;
        if (v.exp_load) push_reads(v.trk);
        tick();
        img_mounted = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (cpu_wait) seen = 1;
            tick();
        end
        check("load_start", seen, v.exp_load);
        if (seen != 0) begin
            wait_done(tv_hi);
            check("valid_while_busy", tv_hi, 0);
        end
        tick();
        check("track_valid", track_valid, v.exp_valid);
        check("cpu_wait_idle", cpu_wait, 0);
        check("queue_drained", exp_q.size(), 0);
        check("buf_we_count", bw_count - bw0, v.exp_bw);
        exp_q.delete();
    endtask

    // SD host: serves each request, checks it against the scoreboard, returns bytes for reads
    initial begin : host
        req_t r, e;
        int hold, nb;
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        sd_buff_addr = 9'd0;
        forever begin
            @(negedge clk_sys);
            if (reset_n && (sd_rd || sd_wr)) begin
                r.wr  = sd_wr;
                r.lba = sd_lba;
                host_sec = 4'(sd_lba % 32'd13);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: actual lba=%0d wr=%0d required no request", r.lba, r.wr);
                end else begin
                    e = exp_q.pop_front();
                    check("req_wr", r.wr, e.wr);
                    check("req_lba", r.lba, e.lba);
                end
                hold = host_fast ? 16 : 520;
                nb   = host_fast ? 4 : 512;
                sd_ack = 1'b1;
                for (int i = 0; i < hold; i++) begin
                    @(negedge clk_sys);
                    if (i == 0) check("req_drop", {sd_rd, sd_wr}, 0);
                    sd_buff_wr   = !r.wr && (i >= 1) && (i < 1 + nb);
                    sd_buff_addr = 9'(i - 1);
                end
                @(negedge clk_sys);
                sd_buff_wr = 1'b0;
                sd_ack = 1'b0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk_sys);
            #2;
            if (buf_we) begin
                bw_count++;
                if (buf_addr != {host_sec, sd_buff_addr}) addr_bad++;
            end
            if (sd_rd && sd_wr) rdwr_both++;
            if (sd_wr) wr_seen++;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vt[6];
        vec_t v;
        int n, busy, tv_hi;

        vt[0] = '{mount:1'b1, size:64'd143360, trk:6'd0,  fast:1'b0, exp_load:1'b1, exp_valid:1'b1, exp_bw:6656};
        vt[1] = '{mount:1'b0, size:64'd143360, trk:6'd5,  fast:1'b1, exp_load:1'b1, exp_valid:1'b1, exp_bw:52};
        vt[2] = '{mount:1'b0, size:64'd143360, trk:6'd5,  fast:1'b1, exp_load:1'b0, exp_valid:1'b1, exp_bw:0};
        vt[3] = '{mount:1'b1, size:64'd0,      trk:6'd5,  fast:1'b1, exp_load:1'b0, exp_valid:1'b0, exp_bw:0};
        vt[4] = '{mount:1'b0, size:64'd0,      trk:6'd9,  fast:1'b1, exp_load:1'b0, exp_valid:1'b0, exp_bw:0};
        vt[5] = '{mount:1'b1, size:64'd143360, trk:6'd9,  fast:1'b1, exp_load:1'b1, exp_valid:1'b1, exp_bw:52};

        reset_n = 1'b0;
        track = 6'd0;
        img_mounted = 1'b0;
        img_size = 64'd0;
        fd_write = 1'b0;
        fd_track_addr = 13'd0;
        tick();
        tick();
        check("rst_outs", {sd_rd, sd_wr, cpu_wait, track_valid, buf_we}, 0);
        check("rst_lba", sd_lba, 0);
        check("rst_buf_addr", buf_addr, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        for (int i = 0; i < 6; i++) run_entry(vt[i]);

        // Retarget to track 7 while the track-3 load is at sector 4
        host_fast = 1'b1;
        push_reads(6'd3);
        push_reads(6'd7);
        track = 6'd3;
        n = 0;
        while (!(sd_lba == 32'd43 && sd_ack) && n < 5000) begin
            tick();
            n++;
        end
        check("reach_sec4", longint'(n < 5000), 1);
        track = 6'd7;
        tick();
        wait_done(tv_hi);
        check("chain_valid_while_busy", tv_hi, 0);
        check("chain_queue_drained", exp_q.size(), 0);
        tick();
        check("chain_track_valid", track_valid, 1);
        exp_q.delete();

        // Reset while sector 6 of track 10 is in flight
        for (int s = 0; s <= 6; s++) push_write(130 + s);
        for (int s = 0; s <= 6; s++) exp_q[s].wr = 1'b0;
        track = 6'd10;
        n = 0;
        while (!(sd_lba == 32'd136 && sd_ack) && n < 5000) begin
            tick();
            n++;
        end
        check("reach_sec6", longint'(n < 5000), 1);
        reset_n = 1'b0;
        #1;
        check("async_rst_outs", {sd_rd, sd_wr, cpu_wait, track_valid, buf_we}, 0);
        check("async_rst_lba", sd_lba, 0);
        for (int i = 0; i < 3; i++) tick();
        reset_n = 1'b1;
        busy = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cpu_wait || sd_rd || sd_wr) busy++;
        end
        check("no_req_after_reset", busy, 0);
        check("rst_queue_drained", exp_q.size(), 0);
        exp_q.delete();
        v = '{mount:1'b1, size:64'd143360, trk:6'd10, fast:1'b1, exp_load:1'b1, exp_valid:1'b1, exp_bw:52};
        run_entry(v);

        // Dirty sectors 5 and 12 on track 2, then move to track 3
        v = '{mount:1'b0, size:64'd143360, trk:6'd2, fast:1'b1, exp_load:1'b1, exp_valid:1'b1, exp_bw:52};
        run_entry(v);
        fd_track_addr = 13'h0A00;
        fd_write = 1'b1;
        tick();
        fd_track_addr = 13'h1800;
        tick();
        fd_write = 1'b0;
        tick();
`ifdef FDD_WRITEBACK_EN
        push_write(31);
        push_write(38);
`endif
        v = '{mount:1'b0, size:64'd143360, trk:6'd3, fast:1'b1, exp_load:1'b1, exp_valid:1'b1, exp_bw:52};
        run_entry(v);
`ifndef FDD_WRITEBACK_EN
        check("no_sd_wr", wr_seen, 0);
`endif

        check("buf_addr_bad", addr_bad, 0);
        check("rd_wr_overlap", rdwr_both, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
